// File: rtl/gcd_ctrl_pkg.sv
// gcd_pack: shared types and constants for the GCD controller.
// Holds the FSM state encoding and the default operand width.
package gcd_pack;

    localparam int GCD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

endpackage

// File: rtl/gcd_ctrl_if.sv
// gcd_ctrl_if: request/result bundle between a GCD client (master)
// and the gcd_ctrl block (slave).
interface gcd_ctrl_if
    import gcd_pack::*;
#(
    parameter int WIDTH = GCD_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             err;
    logic [WIDTH-1:0] iter_cnt;

    modport master (
        output start, a_in, b_in,
        input  busy, done, result, err, iter_cnt
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, result, err, iter_cnt
    );

endinterface

// File: rtl/gcd_ctrl_datapath.sv
// gcd_datapath: operand registers, comparator and subtractor for the
// subtractive GCD. Subtraction is always larger minus smaller, so the
// unsigned registers never wrap.
module gcd_datapath
    import gcd_pack::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] a_o,
    output logic             eq_o
);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_gt_b;

    assign a_gt_b = (a_q > b_q);
    assign eq_o   = (a_q == b_q);
    assign a_o    = a_q;

    // Load operands on an accepted start, otherwise reduce the larger one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (clk_en) begin
            if (load_i) begin
                a_q <= a_i;
                b_q <= b_i;
            end else if (step_i) begin
                if (a_gt_b) begin
                    a_q <= a_q - b_q;
                end else begin
                    b_q <= b_q - a_q;
                end
            end
        end
    end

endmodule

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: start-edge triggered subtractive GCD engine.
// Optional feature macro: GCD_ITER_COUNT_EN -- when defined, iter_cnt
// reports the saturating subtraction count of the last computation;
// otherwise iter_cnt is tied to zero.
module gcd_ctrl
    import gcd_pack::*;
#(
    parameter int WIDTH = GCD_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clk_en,
    gcd_ctrl_if.slave bus
);

    gcd_state_e       state_q, state_d;
    logic             start_hist_q;
    logic             start_edge;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] a_val;
    logic             a_eq_b;

    assign start_edge = bus.start & ~start_hist_q;

    gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .load_i (load),
        .step_i (step),
        .a_i    (bus.a_in),
        .b_i    (bus.b_in),
        .a_o    (a_val),
        .eq_o   (a_eq_b)
    );

    // Start history only advances on enabled edges so a held start never retriggers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_hist_q <= 1'b0;
        end else if (clk_en) begin
            start_hist_q <= bus.start;
        end
    end

    // State, result and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; zero operands short-circuit straight to DONE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
        load     = 1'b0;
        step     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    load  = 1'b1;
                    err_d = 1'b0;
                    if ((bus.a_in == '0) || (bus.b_in == '0)) begin
                        result_d = bus.a_in | bus.b_in;
                        err_d    = (bus.a_in == '0) && (bus.b_in == '0);
                        state_d  = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (a_eq_b) begin
                    result_d = a_val;
                    state_d  = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef GCD_ITER_COUNT_EN
    logic [WIDTH-1:0] iter_q;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Subtraction counter, cleared on accepted start and saturating at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iter_q <= '0;
        end else if (clk_en) begin
            if (load) begin
                iter_q <= '0;
            end else if (step) begin
                iter_q <= sat_inc(iter_q);
            end
        end
    end

    assign bus.iter_cnt = iter_q;
`else
    assign bus.iter_cnt = '0;
`endif

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.err    = err_q;

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result bit width (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clk_en  input  1  clock enable; state advances only on edges with clk_en=1.
REQ-005 SHALL have port start  input  1  level request; rising edge launches a computation.
REQ-006 SHALL have port a_in  input  WIDTH  operand A, sampled on accepted start edge.
REQ-007 SHALL have port b_in  input  WIDTH  operand B, sampled on accepted start edge.
REQ-008 SHALL have port busy  output  1  high while state is RUN or DONE.
REQ-009 SHALL have port done  output  1  high while state is DONE.
REQ-010 SHALL have port result  output  WIDTH  last GCD, held until next accepted start.
REQ-011 SHALL have port err  output  1  set when both sampled operands were zero; cleared on next accepted start.
REQ-012 SHALL have port iter_cnt  output  WIDTH  subtraction count of last computation (see Configuration).

Function
REQ-013 SHALL detect start rising edge internally from a 1-bit history register updated on enabled cycles only.
REQ-014 SHALL implement states IDLE, RUN, DONE, all transitions qualified by clk_en.
REQ-015 IDLE + edge: SHALL load a_reg=a_in, b_reg=b_in, clear err and iter count, go RUN; if either operand zero go DONE directly.
REQ-016 Zero operands: SHALL give result=nonzero operand; both zero -> result=0, err=1.
REQ-017 RUN: a_reg==b_reg SHALL write result=a_reg, go DONE; a_reg>b_reg SHALL set a_reg-=b_reg; else b_reg-=a_reg; stay RUN.
REQ-018 DONE: SHALL hold exactly one enabled cycle, then IDLE.
REQ-019 Latency SHALL be edge cycle + (subtractions+1) RUN cycles + 1 DONE cycle; gcd(12,8): done high 4th enabled cycle after edge cycle.
REQ-020 Start edges while busy=1 SHALL be discarded, not queued; start held high across DONE->IDLE SHALL NOT retrigger.
REQ-021 Subtraction SHALL be unsigned WIDTH-bit, never underflowing (larger minus smaller only).
REQ-022 clk_en=0 SHALL freeze all state and outputs, including the done pulse.

Reset
REQ-023 rst=0 SHALL asynchronously force IDLE, a_reg=b_reg=0, result=0, err=0, iter_cnt=0, busy=0, done=0, edge history=0.
REQ-024 Reset mid-computation SHALL abandon it; no done pulse.
REQ-025 start high at reset release SHALL count as a rising edge on the first enabled cycle.

Configuration
REQ-026 Macro GCD_ITER_COUNT_EN defined: iter_cnt SHALL increment per RUN subtraction, saturating at all-ones, held from DONE until next accepted start.
REQ-027 Macro undefined: iter_cnt SHALL be constant 0, counter logic absent; port list unchanged.

Structure
REQ-028 gcd_pack SHALL hold state enum typedef (IDLE, RUN, DONE) and default width constant GCD_WIDTH=16.
REQ-029 Operand registers, comparator, subtractor SHALL reside in sub-module gcd_datapath; FSM and edge detect stay in gcd_ctrl.

Verification
REQ-030 a=12, b=8, start 0->1 -> done on 4th enabled cycle after edge, result=4, iter_cnt=2 (0 without macro), err=0.
REQ-031 a=9, b=9 -> done on 2nd enabled cycle after edge, result=9, iter_cnt=0.
REQ-032 a=0, b=7 -> DONE next cycle, result=7, err=0; a=0, b=0 -> result=0, err=1.
REQ-033 a=48, b=18, second start edge mid-RUN -> ignored, single done, result=6.
REQ-034 a=12, b=8, clk_en toggled 1/0 alternately -> result=4, latency doubled in clk edges, done held across disabled cycles.
REQ-035 rst=0 asserted during RUN -> all outputs 0 immediately, no done; start high at release -> new computation launches.
